gray_port_arbiter: RTL
======================

# gray_port_arbiter

Shares the single read port of the gray image memory between two LBP-style requesters (engine 0, engine 1), each fetching 3x3 windows as bursts of single-cycle reads. Waits for the memory to report the image is loaded, then grants the port round-robin with a bounded burst length. It also merges the two engines' completion pulses into one sticky frame-level `finish`. It sits between the gray memory interface and the engines; memory read data is combinational (valid in the same cycle as `gray_addr`/`gray_req`).

## Interface
- `MAX_BURST`, 9: maximum consecutive beats granted to one requester while the other is waiting (1..15).
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-low reset.
- `gray_ready` input 1: memory image loaded (level).
- `gray_addr` output 14: read address to memory; 0 when no beat.
- `gray_req` output 1: read strobe; high only on a beat.
- `gray_data` input 8: memory read data, same cycle as `gray_addr`.
- `img_ready` output 1: registered copy of loaded status, sticky until reset.
- `req0`, `req1` input 1: requester wants the port (held for the burst).
- `addr0`, `addr1` input 14: requester read address.
- `gnt0`, `gnt1` output 1: registered grant; at most one high.
- `rdata` output 8: `gray_data` broadcast to both requesters.
- `done0`, `done1` input 1: requester finished its frame share (pulse).
- `finish` output 1: both requesters done; registered, sticky.

## Operation
- States: WAIT_RDY, IDLE, GNT0, GNT1, DONE. Reset -> WAIT_RDY.
- WAIT_RDY: `gnt*`=0. If `gray_ready`=1 -> IDLE and `img_ready`<=1.
- Beat: cycle with `gntN`=1 and `reqN`=1. During a beat: `gray_req`=1, `gray_addr`=`addrN`, requester samples `rdata` in the same cycle. Otherwise `gray_req`=0, `gray_addr`=0.
- Effective request: `reqN` AND NOT `dflagN` (sticky done flag). Done requesters are never granted.
- IDLE: only one effective request -> GNT of that one. Both -> GNT of requester not in `last` (`last` resets to 1, so engine 0 wins first tie). None -> IDLE.
- GNTn, 4-bit beat counter `bcnt` (cleared on grant entry, +1 per beat):
  - `reqN` low: no beat; other effective -> GNTother, else IDLE.
  - Beat with `bcnt`==MAX_BURST-1 and other effective -> GNTother.
  - Otherwise stay. With no competitor, the burst is unbounded; `bcnt` saturates at MAX_BURST-1.
- On each transition out of GNTn: `last`<=n.
- `doneN` pulse sets `dflagN` (sticky). If `doneN` arrives while GNTN, the next state is evaluated as if `reqN` were low.
- When both `dflag` set -> DONE from any of IDLE/GNT0/GNT1. In DONE: `finish`=1, grants 0, held until reset.
- Simultaneous `done0`/`done1` in the same cycle: both flags set, DONE next cycle.

## Timing
- Reset values: `gnt0`=`gnt1`=0, `gray_req`=0, `gray_addr`=0, `img_ready`=0, `finish`=0, `rdata`=`gray_data` (pass-through); `bcnt`=0, `last`=1, `dflag*`=0.
- Grant latency: `reqN` rising in IDLE -> `gntN` high the next cycle; first beat is that cycle.
- Handover: last beat of A in cycle t -> `gntB` in t+1 and B's first beat in t+1 (no bubble).
- Requester protocol: `addrN` must be stable whenever `reqN`=1; a beat completes in one cycle with no wait states.
- `gray_ready` seen high at edge t -> `img_ready` high from t+1. Grants are possible from t+1 cycles onward, the first grant registered at t+2.
- `finish` rises the cycle after the second done flag is set.
- Reset low on any edge, including mid-burst, returns to WAIT_RDY. `gray_ready` must be seen again before any grant.

## Test plan
- Ready gating: hold `req0`=1 with `gray_ready`=0 for 20 cycles -> `gnt0`=0, `gray_req`=0. Raise `gray_ready` -> `img_ready` next cycle, `gnt0` the cycle after.
- Tie and round-robin: after ready, raise `req0`/`req1` together, MAX_BURST=9 -> 9 beats to engine 0 (addresses `addr0` on `gray_addr`), then 9 to engine 1, alternating with no idle cycles.
- Solo burst: only `req0` held for 30 cycles -> 30 consecutive beats, `gnt1` stays 0. Then `req1` arrives -> handover after at most 9 further beats.
- Early release: engine 1 drops `req1` after 3 beats while `req0` waits -> `gnt0` next cycle, `gray_req` low for exactly the drop cycle.
- Finish: pulse `done0`, keep `req0` high -> engine 0 never granted again. Pulse `done1` -> `finish`=1 next cycle, sticky. Reset low mid-burst -> all outputs 0, state WAIT_RDY.

Source files
------------

// File: rtl/gray_port_arbiter_if.sv
// Bus bundle between the gray image memory read port, the two LBP engines
// and the port arbiter. The arbiter uses the slave view; the engine/memory
// side (or a bench) uses the master view.
interface gray_port_arbiter_if;
  // memory side
  logic        gray_ready;
  logic [13:0] gray_addr;
  logic        gray_req;
  logic [7:0]  gray_data;
  logic        img_ready;

  // engine side
  logic        req0;
  logic        req1;
  logic [13:0] addr0;
  logic [13:0] addr1;
  logic        gnt0;
  logic        gnt1;
  logic [7:0]  rdata;
  logic        done0;
  logic        done1;
  logic        finish;

  modport slave (
    input  gray_ready, gray_data,
    input  req0, req1, addr0, addr1, done0, done1,
    output gray_addr, gray_req, img_ready,
    output gnt0, gnt1, rdata, finish
  );

  modport master (
    output gray_ready, gray_data,
    output req0, req1, addr0, addr1, done0, done1,
    input  gray_addr, gray_req, img_ready,
    input  gnt0, gnt1, rdata, finish
  );
endinterface

// File: rtl/gray_port_arbiter.sv
// Round-robin arbiter sharing the gray image memory read port between two
// window-fetch engines. Grants are gated on the memory reporting a loaded
// image, bursts are capped at MAX_BURST beats while the other engine waits,
// and the engines' done pulses are merged into a sticky frame finish.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// WAIT_RDY | image not loaded yet, no grants
// IDLE     | port free, arbitrating among effective requests
// GNT0     | engine 0 owns the port, a beat happens whenever req0 is high
// GNT1     | engine 1 owns the port, a beat happens whenever req1 is high
// DONE     | both engines reported done, finish held until reset
module gray_port_arbiter #(
  parameter int MAX_BURST = 9  // legal range 1..15
) (
  input logic               clk,
  input logic               reset,
  gray_port_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    WAIT_RDY,
    IDLE,
    GNT0,
    GNT1,
    DONE
  } state_t;

  localparam logic [3:0] BCNT_LAST = 4'(MAX_BURST - 1);

  state_t      state;
  logic        gnt0_q;
  logic        gnt1_q;
  logic        img_ready_q;
  logic        finish_q;
  logic        last;
  logic        dflag0;
  logic        dflag1;
  logic [3:0]  bcnt;

  logic        eff0;
  logic        eff1;
  logic        both_done;
  logic        burst_end;
  logic        beat0;
  logic        beat1;

  // A done pulse in the current cycle already disqualifies its requester,
  // so the owner releases the port on the same edge the flag is set.
  always_comb begin
    eff0      = bus.req0 & ~dflag0 & ~bus.done0;
    eff1      = bus.req1 & ~dflag1 & ~bus.done1;
    both_done = (dflag0 | bus.done0) & (dflag1 | bus.done1);
    burst_end = (bcnt == BCNT_LAST);
    beat0     = gnt0_q & bus.req0;
    beat1     = gnt1_q & bus.req1;
  end

  // Memory read port is driven only on a beat; read data is combinational
  // and simply broadcast to both engines.
  always_comb begin
    bus.gray_req  = beat0 | beat1;
    bus.gray_addr = 14'd0;
    if (beat0) begin
      bus.gray_addr = bus.addr0;
    end else if (beat1) begin
      bus.gray_addr = bus.addr1;
    end
    bus.rdata     = bus.gray_data;
    bus.gnt0      = gnt0_q;
    bus.gnt1      = gnt1_q;
    bus.img_ready = img_ready_q;
    bus.finish    = finish_q;
  end

  // Arbitration FSM with registered grants, ready and finish flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= WAIT_RDY;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      img_ready_q <= 1'b0;
      finish_q    <= 1'b0;
      last        <= 1'b1;
      dflag0      <= 1'b0;
      dflag1      <= 1'b0;
      bcnt        <= 4'd0;
    end else begin
      dflag0 <= dflag0 | bus.done0;
      dflag1 <= dflag1 | bus.done1;

      case (state)
        WAIT_RDY: begin
          gnt0_q <= 1'b0;
          gnt1_q <= 1'b0;
          if (bus.gray_ready) begin
            state       <= IDLE;
            img_ready_q <= 1'b1;
          end
        end

        IDLE: begin
          bcnt <= 4'd0;
          if (both_done) begin
            state    <= DONE;
            finish_q <= 1'b1;
          end else if (eff0 && (!eff1 || last)) begin
            // last==1 means engine 1 was served most recently: engine 0 wins ties
            state  <= GNT0;
            gnt0_q <= 1'b1;
          end else if (eff1) begin
            state  <= GNT1;
            gnt1_q <= 1'b1;
          end
        end

        GNT0: begin
          if (both_done) begin
            state    <= DONE;
            gnt0_q   <= 1'b0;
            finish_q <= 1'b1;
            last     <= 1'b0;
          end else if (!eff0 || (burst_end && eff1)) begin
            last   <= 1'b0;
            gnt0_q <= 1'b0;
            bcnt   <= 4'd0;
            if (eff1) begin
              state  <= GNT1;
              gnt1_q <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (!burst_end) begin
            // saturate so an uncontested burst can run indefinitely
            bcnt <= bcnt + 4'd1;
          end
        end

        GNT1: begin
          if (both_done) begin
            state    <= DONE;
            gnt1_q   <= 1'b0;
            finish_q <= 1'b1;
            last     <= 1'b1;
          end else if (!eff1 || (burst_end && eff0)) begin
            last   <= 1'b1;
            gnt1_q <= 1'b0;
            bcnt   <= 4'd0;
            if (eff0) begin
              state  <= GNT0;
              gnt0_q <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (!burst_end) begin
            bcnt <= bcnt + 4'd1;
          end
        end

        DONE: begin
          gnt0_q   <= 1'b0;
          gnt1_q   <= 1'b0;
          finish_q <= 1'b1;
        end

        default: begin
          state  <= WAIT_RDY;
          gnt0_q <= 1'b0;
          gnt1_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
